// File: rtl/aabb_slab_reducer.sv
// aabb_slab_reducer
//   Reduction stage of the ray/AABB intersection pipeline. Takes the six
//   per-axis slab distances of one ray/box pair (FloPoCo wE=11, wF=19 words)
//   and produces:
//     tmin = max(tnear_x, tnear_y, tnear_z)   (entry distance)
//     tmax = min(tfar_x,  tfar_y,  tfar_z)    (exit distance)
//     hit  = (tmax >= tmin) && (tmax >= 0) && no inf/NaN input
//   Two pipelined greater-or-equal units are reused over three passes
//   (P1, P2, P3). Each pass holds its operands for CMP_LAT cycles.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (see below)
//   tnear_x/y/z           slab entry distances, [width:0] FloPoCo words
//   tfar_x/y/z            slab exit distances,  [width:0] FloPoCo words
//   out_valid             one-cycle pulse, hit/t_enter valid
//   hit                   ray intersects the box
//   t_enter               tmin when hit, otherwise all-zero
//
// Handshake: a pair transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE; it rises on the same edge
// that raises out_valid, so the next pair can transfer during the out_valid
// cycle. in_valid may be held high; inputs are sampled only on the transfer
// edge. hit and t_enter hold until the next result.
module aabb_slab_reducer #(
  parameter int width   = 32,
  parameter int CMP_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [width:0] tnear_x,
  input  logic [width:0] tnear_y,
  input  logic [width:0] tnear_z,
  input  logic [width:0] tfar_x,
  input  logic [width:0] tfar_y,
  input  logic [width:0] tfar_z,
  output logic           out_valid,
  output logic           hit,
  output logic [width:0] t_enter
);

  localparam int W  = width + 1;
  localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CMP_LAT - 1);

  typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  // Operand registers: unit A compares (a0, a1), unit B compares (b0, b1).
  logic [W-1:0]  a0_q, a1_q, b0_q, b1_q;
  logic [W-1:0]  a0_d, a1_d, b0_d, b1_d;
  // z-axis distances are only needed from P2 on.
  logic [W-1:0]  nz_q, fz_q, nz_d, fz_d;
  logic          bad_q, bad_d;
  logic          out_valid_d, hit_d;
  logic [W-1:0]  t_enter_d;

  // x >= y on FloPoCo words. Zeros compare equal regardless of sign.
  // Magnitude key is {exception, exp, frac} with exp/frac cleared for zero
  // and inf, so zero < normal < inf. NaN is unordered (result 0); such a
  // pair is already flagged bad, this only keeps the result deterministic.
  function automatic logic fp_ge(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [1:0]   ex, ey;
    logic         nx, ny;
    logic [W-2:0] mx, my;
    ex = x[width:width-1];
    ey = y[width:width-1];
    nx = x[width-2] & (ex != 2'b00);
    ny = y[width-2] & (ey != 2'b00);
    mx = {ex, (ex == 2'b01) ? x[width-3:0] : {(width-2){1'b0}}};
    my = {ey, (ey == 2'b01) ? y[width-3:0] : {(width-2){1'b0}}};
    if (ex == 2'b11 || ey == 2'b11) return 1'b0;
    if (nx != ny)                   return ny;
    if (nx)                         return mx <= my;
    return mx >= my;
  endfunction

  // Two greater-or-equal units: compare stage plus flag register, CMP_LAT-1
  // flops deep, so the flag is stable before the pass-ending edge.
  logic [CMP_LAT-2:0] pipe_a, pipe_b;
  logic               ge_a, ge_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      pipe_a[0] <= fp_ge(a0_q, a1_q);
      pipe_b[0] <= fp_ge(b0_q, b1_q);
      for (int i = 1; i < CMP_LAT - 1; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign ge_a = pipe_a[CMP_LAT-2];
  assign ge_b = pipe_b[CMP_LAT-2];

  // Same selection in P1 and P2: larger of the near pair (tie -> a0),
  // smaller of the far pair (b0 >= b1 -> b1, tie -> b1).
  logic [W-1:0] near_pick, far_pick;
  assign near_pick = ge_a ? a0_q : a1_q;
  assign far_pick  = ge_b ? b1_q : b0_q;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    nz_d        = nz_q;
    fz_d        = fz_q;
    bad_d       = bad_q;
    out_valid_d = 1'b0;
    hit_d       = hit;
    t_enter_d   = t_enter;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a0_d    = tnear_x;
          a1_d    = tnear_y;
          b0_d    = tfar_x;
          b1_d    = tfar_y;
          nz_d    = tnear_z;
          fz_d    = tfar_z;
          bad_d   = tnear_x[width] | tnear_y[width] | tnear_z[width] |
                    tfar_x[width]  | tfar_y[width]  | tfar_z[width];
          wait_d  = '0;
          state_d = P1;
        end
      end
      P1: begin
        if (wait_q == LAST) begin
          a0_d    = near_pick;
          a1_d    = nz_q;
          b0_d    = far_pick;
          b1_d    = fz_q;
          wait_d  = '0;
          state_d = P2;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      P2: begin
        if (wait_q == LAST) begin
          // A: tmax >= tmin, B: tmax >= +0. a1 keeps tmin for the result.
          a0_d    = far_pick;
          a1_d    = near_pick;
          b0_d    = far_pick;
          b1_d    = '0;
          wait_d  = '0;
          state_d = P3;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      P3: begin
        if (wait_q == LAST) begin
          hit_d       = ge_a & ge_b & ~bad_q;
          t_enter_d   = (ge_a & ge_b & ~bad_q) ? a1_q : '0;
          out_valid_d = 1'b1;
          wait_d      = '0;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        wait_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      nz_q      <= '0;
      fz_q      <= '0;
      bad_q     <= 1'b0;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      t_enter   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      nz_q      <= nz_d;
      fz_q      <= fz_d;
      bad_q     <= bad_d;
      out_valid <= out_valid_d;
      hit       <= hit_d;
      t_enter   <= t_enter_d;
    end
  end

endmodule

// File: tb/tb_aabb_slab_reducer.sv
// Testbench for aabb_slab_reducer: directed ray/box pairs with hand-computed
// results. The driver pushes {hit, t_enter} into exp_q when it issues a pair;
// an edge process logs accept edges; the monitor pops and compares on every
// out_valid, including the 3*CMP_LAT latency.
module tb_aabb_slab_reducer;

  localparam int WIDTH   = 32;
  localparam int CMP_LAT = 4;
  localparam int LAT     = 3 * CMP_LAT;

  // FloPoCo encodings: [32:31] exc, [30] sign, [29:19] exp (bias 1023), [18:0] frac
  localparam logic [32:0] P0_0  = 33'h0_0000_0000;  // +0
  localparam logic [32:0] N0_0  = 33'h0_4000_0000;  // -0
  localparam logic [32:0] P0_5  = 33'h0_9FF0_0000;
  localparam logic [32:0] P1_0  = 33'h0_9FF8_0000;
  localparam logic [32:0] P2_0  = 33'h0_A000_0000;
  localparam logic [32:0] P3_0  = 33'h0_A004_0000;
  localparam logic [32:0] P4_0  = 33'h0_A008_0000;
  localparam logic [32:0] P5_0  = 33'h0_A00A_0000;
  localparam logic [32:0] P6_0  = 33'h0_A00C_0000;
  localparam logic [32:0] P9_0  = 33'h0_A011_0000;
  localparam logic [32:0] N0_5  = 33'h0_DFF0_0000;
  localparam logic [32:0] N1_0  = 33'h0_DFF8_0000;
  localparam logic [32:0] N2_0  = 33'h0_E000_0000;
  localparam logic [32:0] N4_0  = 33'h0_E008_0000;
  localparam logic [32:0] N5_0  = 33'h0_E00A_0000;
  localparam logic [32:0] N6_0  = 33'h0_E00C_0000;
  localparam logic [32:0] QNAN  = 33'h1_A000_0000;  // exc 11

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, hit;
  logic [32:0] tnear_x, tnear_y, tnear_z, tfar_x, tfar_y, tfar_z, t_enter;

  aabb_slab_reducer #(.width(WIDTH), .CMP_LAT(CMP_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .tnear_x(tnear_x), .tnear_y(tnear_y), .tnear_z(tnear_z),
    .tfar_x(tfar_x), .tfar_y(tfar_y), .tfar_z(tfar_z),
    .out_valid(out_valid), .hit(hit), .t_enter(t_enter)
  );

  // scoreboard state
  logic [33:0] exp_q[$];   // {hit, t_enter}
  int          acc_q[$];   // accept edge numbers
  int          edge_n = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // edge numbering and accept log
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst && in_valid && in_ready) acc_q.push_back(edge_n);
  end

  // monitor
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: got out_valid=1 hit=%0b t_enter=%0h expected no result", hit, t_enter);
      end else begin
        logic [33:0] e;
        int          a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("hit", 64'(hit), 64'(e[33]));
        check("t_enter", 64'(t_enter), 64'(e[32:0]));
        check("latency", 64'(edge_n - a), 64'(LAT));
        check("in_ready_at_out", 64'(in_ready), 64'd1);
      end
    end
  end

  // drivers
  task automatic send(input logic [32:0] nx, ny, nz, fx, fy, fz,
                      input logic eh, input logic [32:0] et, input bit push,
                      output int acc_edge);
    int n;
    @(negedge clk);
    tnear_x = nx; tnear_y = ny; tnear_z = nz;
    tfar_x  = fx; tfar_y  = fy; tfar_z  = fz;
    in_valid = 1'b1;
    if (push) exp_q.push_back({eh, et});
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 acc_edge = edge_n;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_hit"}, 64'(hit), 64'd0);
    check({tag, "_t_enter"}, 64'(t_enter), 64'd0);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int e0, e1;
    rst = 1'b1;
    in_valid = 1'b0;
    tnear_x = '0; tnear_y = '0; tnear_z = '0;
    tfar_x  = '0; tfar_y  = '0; tfar_z  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // near=(1,2,0.5) far=(5,3,4): tmin=2, tmax=3 -> hit, t_enter=2.0
    send(P1_0, P2_0, P0_5, P5_0, P3_0, P4_0, 1'b1, P2_0, 1'b1, e0); idle(); drain();
    // near=(1,4,0) far=(3,6,9): tmin=4 > tmax=3 -> miss
    send(P1_0, P4_0, P0_0, P3_0, P6_0, P9_0, 1'b0, P0_0, 1'b1, e0); idle(); drain();
    // box behind ray: tmax=-2 < 0 -> miss
    send(N5_0, N4_0, N6_0, N1_0, N2_0, N0_5, 1'b0, P0_0, 1'b1, e0); idle(); drain();
    // far=(1,+0,1): tmax=+0, tmin=-4 -> hit, t_enter=-4.0
    send(N5_0, N4_0, N6_0, P1_0, P0_0, P1_0, 1'b1, N4_0, 1'b1, e0); idle(); drain();
    // far=(1,-0,1): -0 >= +0 still holds -> hit, t_enter=-4.0
    send(N5_0, N4_0, N6_0, P1_0, N0_0, P1_0, 1'b1, N4_0, 1'b1, e0); idle(); drain();
    // NaN on tnear_y -> miss, latency unchanged
    send(P1_0, QNAN, P0_5, P5_0, P3_0, P4_0, 1'b0, P0_0, 1'b1, e0); idle(); drain();
    // near=(-0,+0,-1): tie keeps first operand, tmin=-0 word
    send(N0_0, P0_0, N1_0, P1_0, P1_0, P1_0, 1'b1, N0_0, 1'b1, e0); idle(); drain();
    // all six equal to 1.0 -> hit, t_enter=1.0
    send(P1_0, P1_0, P1_0, P1_0, P1_0, P1_0, 1'b1, P1_0, 1'b1, e0); idle(); drain();

    // back-to-back with in_valid held; second pair's inputs sit on the
    // ports while the first is in flight. It transfers on the edge ending
    // the out_valid cycle: LAT edges to register the result, plus one.
    send(P1_0, P2_0, P0_5, P5_0, P3_0, P4_0, 1'b1, P2_0, 1'b1, e0);
    send(P1_0, P4_0, P0_0, P3_0, P6_0, P9_0, 1'b0, P0_0, 1'b1, e1);
    idle(); drain();
    check("b2b_accept_spacing", 64'(e1 - e0), 64'(LAT + 1));

    // reset in the middle of P2: pair dropped, outputs return to reset values
    send(P1_0, P1_0, P1_0, P1_0, P1_0, P1_0, 1'b1, P1_0, 1'b1, e0); idle(); drain();
    send(P1_0, P2_0, P0_5, P5_0, P3_0, P4_0, 1'b1, P2_0, 1'b0, e0); idle();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    repeat (3 * LAT) @(negedge clk);   // monitor reports any stray out_valid
    send(N5_0, N4_0, N6_0, P1_0, P0_0, P1_0, 1'b1, N4_0, 1'b1, e0); idle(); drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
